ad9361_spi_slave: RTL

- Behavioural SPI responder that emulates the AD9361 register port: the far end of the AD9361_SPI_CLK/ENB/DI/DO master pins.
- Used for loopback bring-up and in the system bench, so the SPI master and its software can be exercised without a transceiver fitted.
- Oversamples the SPI pins in the system clock domain and holds a small flop-based register file.
- Decodes AD9361 instruction words (16-bit instruction, multibyte transfers with decrementing address) and drives read data back on DO.

---
 rtl/ad9361_spi_pkg.sv | 22 ++
 rtl/spi_pin_sync.sv | 38 +++
 rtl/ad9361_spi_slave.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ad9361_spi_pkg.sv
// Shared types and field positions for the AD9361 SPI register-port responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ad9361_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Instruction word layout, MSB first on the wire
    localparam int RW_BIT    = 15;
    localparam int NB_MSB    = 14;
    localparam int NB_LSB    = 12;
    localparam int ADDR_W    = 10;

    localparam int INSTR_LEN = 16;
    localparam int BYTE_LEN  = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags spi_clk edges.
// Latency: 2 clk to the synchronised levels; edge strobes act on the 3rd clk after the pin edge.
// Backpressure: none; the pins are sampled every clk.
module spi_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_enb,
    input  logic spi_di,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic enb_s,
    output logic di_s
);

    logic [2:0] sclk_sr;
    logic [1:0] enb_sr;
    logic [1:0] di_sr;

    // Two-flop synchronisers plus one history flop on spi_clk; enable resets deasserted (high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr <= 3'b000;
            enb_sr  <= 2'b11;
            di_sr   <= 2'b00;
        end else begin
            sclk_sr <= {sclk_sr[1:0], spi_clk};
            enb_sr  <= {enb_sr[0], spi_enb};
            di_sr   <= {di_sr[0], spi_di};
        end
    end

    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign enb_s     = enb_sr[1];
    assign di_s      = di_sr[1];

endmodule

// File: rtl/ad9361_spi_slave.sv
// Behavioural AD9361 SPI register port: decodes instructions, holds a flop register file, returns read data.
// Latency: write commits 1 clk after the 8th synchronised rise of a byte; read bits appear ~3 clk after each spi_clk fall.
// Backpressure: none; the SPI master paces all traffic, clk must run at least 8x spi_clk.
module ad9361_spi_slave #(
    parameter int          DEPTH   = 64,
    parameter logic [9:0]  ID_ADDR = 10'h037,
    parameter logic [7:0]  ID_VAL  = 8'h0A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_enb,
    input  logic       spi_di,
    output logic       spi_do,
    output logic       spi_do_oe,
    output logic       wr_stb,
    output logic [9:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       err_abort
);

    import ad9361_spi_pkg::*;

    localparam int                AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic sclk_rise, sclk_fall, enb_s, di_s;
    logic enb_prev, enb_fall;

    state_t state, state_nxt;

    logic [3:0]          bit_cnt;
    logic [14:0]         instr_sr;
    logic [15:0]         instr_word;
    logic                rw;
    logic [2:0]          nb;
    logic [ADDR_W-1:0]   addr;
    logic [3:0]          byte_cnt;
    logic [6:0]          data_sr;
    logic [7:0]          wr_byte;
    logic [7:0]          out_sr;
    logic [7:0]          rd_q;
    logic                rd_vld;

    logic                abort;
    logic                instr_done;
    logic                byte_done;
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
    logic [7:0]          rd_byte;
    logic                wr_en;

    logic [7:0] mem [DEPTH];

    spi_pin_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_enb   (spi_enb),
        .spi_di    (spi_di),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .enb_s     (enb_s),
        .di_s      (di_s)
    );

    assign enb_fall   = enb_prev & ~enb_s;
    assign instr_word = {instr_sr, di_s};
    assign wr_byte    = {data_sr, di_s};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and per-cycle control strobes; enable-high takes priority over clock edges
    always_comb begin
        state_nxt  = state;
        abort      = 1'b0;
        instr_done = 1'b0;
        byte_done  = 1'b0;
        case (state)
            IDLE: begin
                if (enb_fall) state_nxt = INSTR;
            end
            INSTR: begin
                if (enb_s) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_rise && bit_cnt == 4'(INSTR_LEN - 1)) begin
                    instr_done = 1'b1;
                    state_nxt  = DATA;
                end
            end
            DATA: begin
                if (enb_s) begin
                    // Leaving on a byte boundary is a legal early stop; mid-byte is an error
                    abort     = (bit_cnt != 4'd0);
                    state_nxt = IDLE;
                end else if (sclk_rise && bit_cnt == 4'(BYTE_LEN - 1)) begin
                    byte_done = 1'b1;
                    if (byte_cnt == {1'b0, nb}) state_nxt = DONE;
                end
            end
            DONE: begin
                if (enb_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read-port address, request and address-map lookup (ID register, implemented, or zero)
    always_comb begin
        rd_addr = instr_done ? instr_word[ADDR_W-1:0] : addr - 1'b1;
        rd_req  = (instr_done && !instr_word[RW_BIT]) || (byte_done && !rw && state_nxt == DATA);
        rd_byte = 8'h00;
        if (rd_addr == ID_ADDR)
            rd_byte = ID_VAL;
        else if ({1'b0, rd_addr} < DEPTH_L)
            rd_byte = mem[rd_addr[AW-1:0]];
        wr_en   = byte_done && rw && ({1'b0, addr} < DEPTH_L) && (addr != ID_ADDR);
    end

    // Register file; cleared by reset, the ID location is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else if (wr_en) begin
            mem[addr[AW-1:0]] <= wr_byte;
        end
    end

    // Shift registers, counters, write strobe and read-data driver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enb_prev  <= 1'b1;
            bit_cnt   <= 4'd0;
            instr_sr  <= 15'd0;
            rw        <= 1'b0;
            nb        <= 3'd0;
            addr      <= '0;
            byte_cnt  <= 4'd0;
            data_sr   <= 7'd0;
            out_sr    <= 8'h00;
            rd_q      <= 8'h00;
            rd_vld    <= 1'b0;
            spi_do    <= 1'b0;
            spi_do_oe <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= 10'd0;
            wr_data   <= 8'h00;
            err_abort <= 1'b0;
        end else begin
            enb_prev  <= enb_s;
            err_abort <= abort;
            wr_stb    <= 1'b0;
            rd_vld    <= rd_req;
            if (rd_req) rd_q <= rd_byte;

            case (state)
                IDLE: begin
                    bit_cnt <= 4'd0;
                end
                INSTR: begin
                    if (sclk_rise) begin
                        instr_sr <= instr_word[14:0];
                        bit_cnt  <= bit_cnt + 4'd1;
                    end
                    if (instr_done) begin
                        rw       <= instr_word[RW_BIT];
                        nb       <= instr_word[NB_MSB:NB_LSB];
                        addr     <= instr_word[ADDR_W-1:0];
                        byte_cnt <= 4'd0;
                        bit_cnt  <= 4'd0;
                    end
                end
                DATA: begin
                    if (sclk_rise && !enb_s) begin
                        data_sr <= wr_byte[6:0];
                        bit_cnt <= (bit_cnt == 4'(BYTE_LEN - 1)) ? 4'd0 : bit_cnt + 4'd1;
                    end
                    if (byte_done) begin
                        if (rw) begin
                            wr_stb  <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= wr_byte;
                        end
                        addr     <= addr - 1'b1;
                        byte_cnt <= byte_cnt + 4'd1;
                    end
                end
                default: ;
            endcase

            // Read data leaves on spi_clk falls only while a read stays in DATA
            if (state == DATA && !rw && state_nxt == DATA) begin
                if (sclk_fall) begin
                    spi_do    <= out_sr[7];
                    spi_do_oe <= 1'b1;
                    out_sr    <= {out_sr[6:0], 1'b0};
                end
            end else begin
                spi_do    <= 1'b0;
                spi_do_oe <= 1'b0;
            end
            // Fetched byte lands well before the next fall, so it never collides with a shift
            if (rd_vld) out_sr <= rd_q;
        end
    end

endmodule
